// File: rtl/spi_frame_rx_if.sv
// Purpose : bundles the SPI receive pins and the per-channel RAM write port of spi_frame_rx.
// Latency : none; this is wiring only.
// Backpressure: none; the RAM side must accept every write strobe it is given.
// Ports   : spi_cs_n_in/spi_mosi_in (SPI side), wr_en_out/wr_addr_out/wr_data_out (RAM write),
//           busy_out/frame_err_out (status). The slave modport is the receiver's view.
interface spi_frame_rx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_CH     = 4
);
  logic                  spi_cs_n_in;
  logic                  spi_mosi_in;
  logic [NUM_CH-1:0]     wr_en_out;
  logic [ADDR_WIDTH-1:0] wr_addr_out;
  logic [DATA_WIDTH-1:0] wr_data_out;
  logic                  busy_out;
  logic                  frame_err_out;

  modport slave (
    input  spi_cs_n_in, spi_mosi_in,
    output wr_en_out, wr_addr_out, wr_data_out, busy_out, frame_err_out
  );

  modport master (
    output spi_cs_n_in, spi_mosi_in,
    input  wr_en_out, wr_addr_out, wr_data_out, busy_out, frame_err_out
  );
endinterface

// File: rtl/spi_frame_rx.sv
// Purpose : SPI mode-0 receive slave; first word of a frame is a command, later words write a channel RAM.
// Latency : write strobe asserts on the sclk rising edge that captures the last bit of a data word.
// Backpressure: none; strobes last one sclk period and the RAM samples them on the falling edge.
// Ports   : spi_sclk_in (clock), rst_n_in (async active-low reset), bus (spi_frame_rx_if.slave):
//           SPI cs/mosi in, one-hot wr_en/wr_addr/wr_data out, busy and frame error status out.
module spi_frame_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int NUM_CH     = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic           spi_sclk_in,
  input  logic           rst_n_in,
  spi_frame_rx_if.slave  bus
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_CMD    = 2'd0,
    S_ADDR   = 2'd1,
    S_DATA   = 2'd2,
    S_IGNORE = 2'd3
  } state_t;

  // Frame-scoped state is cleared both by reset and by cs going high, so the
  // two are merged into a single asynchronous clear.
  logic abort_n;
  assign abort_n = rst_n_in & ~bus.spi_cs_n_in;

  state_t                state_q, state_d;
  logic [BW-1:0]         bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] word;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         ch_q, ch_d;
  logic [NUM_CH-1:0]     wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  busy_q;
  logic                  err_q, err_d;
  logic                  word_done;
  logic                  strobe;
  logic                  ch_ok;
  logic                  addr_ok;
  logic                  addr_last;

  // The word seen on the completing edge already contains the bit being sampled.
  generate
    if (MSB_FIRST) begin : g_msb
      assign word = {shift_q[DATA_WIDTH-2:0], bus.spi_mosi_in};
    end else begin : g_lsb
      assign word = {bus.spi_mosi_in, shift_q[DATA_WIDTH-1:1]};
    end
  endgenerate

  assign word_done = ~bus.spi_cs_n_in && (bit_cnt_q == BW'(DATA_WIDTH - 1));
  assign ch_ok     = 32'(word[CW-1:0]) < 32'(NUM_CH);
  assign addr_ok   = 32'(word[ADDR_WIDTH-1:0]) < 32'(DEPTH);
  assign addr_last = (addr_q == ADDR_WIDTH'(DEPTH - 1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ch_d    = ch_q;
    err_d   = err_q;
    strobe  = 1'b0;
    if (word_done) begin
      case (state_q)
        S_CMD: begin
          ch_d = word[CW-1:0];
          if (!word[DATA_WIDTH-1]) begin
            // opcodes 00/01 are not ours; the error flag keeps its last value
            state_d = S_IGNORE;
          end else if (!ch_ok) begin
            err_d   = 1'b1;
            state_d = S_IGNORE;
          end else begin
            err_d = 1'b0;
            if (word[DATA_WIDTH-2]) begin
              state_d = S_ADDR;
            end else begin
              addr_d  = '0;
              state_d = S_DATA;
            end
          end
        end
        S_ADDR: begin
          if (addr_ok) begin
            addr_d  = word[ADDR_WIDTH-1:0];
            state_d = S_DATA;
          end else begin
            err_d   = 1'b1;
            state_d = S_IGNORE;
          end
        end
        S_DATA: begin
          strobe = 1'b1;
          addr_d = addr_last ? '0 : addr_q + ADDR_WIDTH'(1);
        end
        default: ;
      endcase
    end
    wr_en_d = strobe ? (NUM_CH'(1) << ch_q) : '0;
  end

  always_ff @(posedge spi_sclk_in or negedge abort_n) begin
    if (!abort_n) begin
      state_q   <= S_CMD;
      bit_cnt_q <= '0;
      wr_en_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= word_done ? '0 : bit_cnt_q + BW'(1);
      wr_en_q   <= wr_en_d;
      busy_q    <= (state_d == S_ADDR) || (state_d == S_DATA);
    end
  end

  // Values that must survive cs going high (write port, error flag) or that are
  // harmlessly stale across frames (shift register, address, channel).
  always_ff @(posedge spi_sclk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      shift_q   <= '0;
      addr_q    <= '0;
      ch_q      <= '0;
      err_q     <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (!bus.spi_cs_n_in) begin
      shift_q <= word;
      addr_q  <= addr_d;
      ch_q    <= ch_d;
      err_q   <= err_d;
      if (strobe) begin
        wr_addr_q <= addr_q;
        wr_data_q <= word;
      end
    end
  end

  assign bus.wr_en_out     = wr_en_q;
  assign bus.wr_addr_out   = wr_addr_q;
  assign bus.wr_data_out   = wr_data_q;
  assign bus.busy_out      = busy_q;
  assign bus.frame_err_out = err_q;

endmodule

// File: doc/spi_frame_rx.md
Name: spi_frame_rx

Overview:
Parametrised SPI-mode-0 receive slave running entirely in the spi_sclk_in domain. It deserialises MOSI into DATA_WIDTH-bit words and decodes the first word of each CS frame as a command: opcode, start-address mode and target channel. Following words become auto-incrementing write strobes into one of NUM_CH per-channel LED frame RAMs. It replaces the fixed 8-bit single-RAM receiver and adds channel select, start address, bit order and error reporting.

Parameters:
DATA_WIDTH, 8, word width in bits; legal range 4..32; also the width of the command word.
ADDR_WIDTH, 8, RAM address width; must be <= DATA_WIDTH.
DEPTH, 256, number of RAM words per channel; address wrap point; 1 <= DEPTH <= 2**ADDR_WIDTH.
NUM_CH, 4, number of RAM channels; legal range 1..16.
MSB_FIRST, 1, 1 = first bit received lands in the word MSB; 0 = first bit received lands in the LSB.

Ports:
spi_sclk_in  input  1  SPI clock; all state updates on its rising edge.
rst_n_in  input  1  Reset: asynchronous, active-low; clock is spi_sclk_in.
spi_cs_n_in  input  1  Chip select, active low; high level asynchronously aborts the frame.
spi_mosi_in  input  1  Serial data; sampled on spi_sclk_in rising edge.
wr_en_out  output  NUM_CH  One-hot write strobe; bit n selects channel n.
wr_addr_out  output  ADDR_WIDTH  Write address qualified by wr_en_out.
wr_data_out  output  DATA_WIDTH  Write data qualified by wr_en_out.
busy_out  output  1  High while a frame is past its command word (states S_ADDR/S_DATA).
frame_err_out  output  1  Last command was invalid; level output.

Behaviour:
- Reset (rst_n_in low, async): state S_CMD, bit counter 0, shift register 0, address register 0, channel 0.
- Reset output values: wr_en_out 0, wr_addr_out 0, wr_data_out 0, busy_out 0, frame_err_out 0.
- spi_cs_n_in high (async, level): state S_CMD, bit counter 0, wr_en_out 0, busy_out 0. wr_addr_out, wr_data_out and frame_err_out hold their values. A partial word is discarded.
- Shifting: each rising edge with cs low shifts in MOSI; direction set by MSB_FIRST. The bit counter runs 0..DATA_WIDTH-1 and wraps to 0.
- Word complete: the edge that captures bit DATA_WIDTH-1. The assembled word W includes that bit, with no extra latency.
- Command decode: opcode = W[DATA_WIDTH-1:DATA_WIDTH-2]. Channel ch = W[CW-1:0], where CW = max(1, clog2(NUM_CH)).
- S_CMD, opcode 2'b10, ch < NUM_CH: addr <= 0, go S_DATA, frame_err_out <= 0.
- S_CMD, opcode 2'b11, ch < NUM_CH: go S_ADDR, frame_err_out <= 0.
- S_CMD, opcode 2'b00 or 2'b01: go S_IGNORE; frame_err_out unchanged.
- S_CMD, ch >= NUM_CH with opcode 1x: go S_IGNORE, frame_err_out <= 1.
- S_ADDR, W[ADDR_WIDTH-1:0] < DEPTH: addr <= that value, go S_DATA.
- S_ADDR, value >= DEPTH: frame_err_out <= 1, go S_IGNORE.
- S_DATA, each word complete:
  - wr_en_out <= one-hot(ch), wr_data_out <= W, wr_addr_out <= addr.
  - addr <= (addr == DEPTH-1) ? 0 : addr+1.
- S_IGNORE: words are shifted and dropped; no strobes until cs rises.
- Strobe timing: wr_en_out is high for exactly one sclk period, from the completing rising edge to the next rising edge. It drops early if cs rises or reset asserts. Consumers sample it on the falling edge of spi_sclk_in.
- Back-to-back strobes are impossible, because DATA_WIDTH >= 4.
- busy_out = (state is S_ADDR or S_DATA), registered.
- cs low glitch between frames with no sclk edges: no state change.

Test Plan:
- Reset, DATA_WIDTH=8, NUM_CH=4, MSB_FIRST=1: send 0x82 then 0xA5, 0x3C -> ch2 strobes at addr 0 data 0xA5, then addr 1 data 0x3C; wr_en_out=4'b0100 for one sclk each; busy_out high after the command word.
- Command 0xC1, address 0xFE, then data 0x11, 0x22, 0x33 with DEPTH=256 -> ch1 writes at addresses 0xFE, 0xFF, 0x00 (wrap).
- Command 0x80, then cs rises after 5 bits of the second word -> no strobe; next frame 0x80 + 0x55 -> write at addr 0 data 0x55.
- NUM_CH=3, command 0x83 -> frame_err_out=1 and no strobes for the whole frame; next command 0x80 -> frame_err_out=0.
- MSB_FIRST=0: serial bit sequence 1,0,1,0,0,0,0,0 for the command decodes as 0x05 (opcode 00, ignored).
- MSB_FIRST=0: command 0x81 sent LSB first, then data 0xF0 -> ch1 write at addr 0 data 0xF0.
- Assert rst_n_in mid-S_DATA while wr_en_out is high -> all outputs 0 immediately; the following frame decodes normally.
